// File: rtl/dmem_pkg.sv
// Shared data-memory constants for the swt16 MEM stage and the dmem responder.
package dmem_pkg;

    localparam int DMEM_ADDR_WIDTH = 12;
    localparam int DMEM_WORD_WIDTH = 16;
    localparam int DMEM_DEPTH      = 4096;

    localparam logic STATE_CLEAR = 1'b0;
    localparam logic STATE_READY = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Plain 1R1W synchronous storage with read-first behaviour; drop-in slot for a vendor RAM macro.
module dmem_array #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4096
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_word,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_word
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the storage so it maps onto block RAM; zeroing is the owner's job.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
        rd_word <= mem[rd_addr];
    end

endmodule

// File: rtl/dmem.sv
// Data memory responder: post-reset clear sweep, write-first collision bypass,
// range checking and registered read data with one-cycle latency.
module dmem #(
    parameter int DMEM_ADDR_WIDTH = dmem_pkg::DMEM_ADDR_WIDTH,
    parameter int DMEM_WORD_WIDTH = dmem_pkg::DMEM_WORD_WIDTH,
    parameter int DMEM_DEPTH      = dmem_pkg::DMEM_DEPTH,
    parameter bit CLEAR_ON_RESET  = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word,
    input  logic                       in_mem_write_en,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_rd_word,
    output logic                       out_busy,
    output logic                       out_addr_err
);

    import dmem_pkg::*;

    localparam int IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [DMEM_ADDR_WIDTH:0] DEPTH_EXT   = (DMEM_ADDR_WIDTH+1)'(DMEM_DEPTH);
    localparam logic [DMEM_ADDR_WIDTH:0] LAST_IDX    = DEPTH_EXT - (DMEM_ADDR_WIDTH+1)'(1);
    localparam logic                     RESET_STATE = CLEAR_ON_RESET ? STATE_CLEAR : STATE_READY;

    logic                       state_q;
    logic [DMEM_ADDR_WIDTH:0]   clr_cnt_q;
    logic                       rd_ok_q;
    logic                       bypass_q;
    logic [DMEM_WORD_WIDTH-1:0] bypass_word_q;
    logic                       addr_err_q;

    logic                       ready;
    logic                       rd_in_range;
    logic                       wr_in_range;
    logic                       user_wr;
    logic                       arr_we;
    logic [IDX_W-1:0]           arr_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] arr_wr_word;
    logic [DMEM_WORD_WIDTH-1:0] arr_rd_word;

    // Counter is one bit wider than the address so a full-depth sweep ends without wrapping.
    assign ready       = (state_q == STATE_READY);
    assign rd_in_range = ({1'b0, in_mem_rd_addr} < DEPTH_EXT);
    assign wr_in_range = ({1'b0, in_mem_wr_addr} < DEPTH_EXT);
    assign user_wr     = ready && in_mem_write_en && wr_in_range;

    assign arr_we      = !ready || user_wr;
    assign arr_wr_addr = ready ? in_mem_wr_addr[IDX_W-1:0] : clr_cnt_q[IDX_W-1:0];
    assign arr_wr_word = ready ? in_mem_wr_word : '0;

    dmem_array #(
        .ADDR_WIDTH (IDX_W),
        .WORD_WIDTH (DMEM_WORD_WIDTH),
        .DEPTH      (DMEM_DEPTH)
    ) u_array (
        .clock   (clock),
        .wr_en   (arr_we),
        .wr_addr (arr_wr_addr),
        .wr_word (arr_wr_word),
        .rd_addr (in_mem_rd_addr[IDX_W-1:0]),
        .rd_word (arr_rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else if (!ready) begin
            clr_cnt_q <= clr_cnt_q + (DMEM_ADDR_WIDTH+1)'(1);
            if (clr_cnt_q == LAST_IDX) begin
                state_q <= STATE_READY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ok_q       <= 1'b0;
            bypass_q      <= 1'b0;
            bypass_word_q <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            rd_ok_q       <= ready && rd_in_range;
            bypass_q      <= user_wr && rd_in_range && (in_mem_rd_addr == in_mem_wr_addr);
            bypass_word_q <= in_mem_wr_word;
            addr_err_q    <= ready && (!rd_in_range || (in_mem_write_en && !wr_in_range));
        end
    end

    // The array reads old data on a collision, so the captured write word overrides it.
    assign out_mem_rd_word = !rd_ok_q ? '0 : (bypass_q ? bypass_word_q : arr_rd_word);
    assign out_busy        = (state_q == STATE_CLEAR);
    assign out_addr_err    = addr_err_q;

endmodule
